// File: rtl/neurosync_pkg.sv
// -----------------------------------------------------------------------------
// neurosync_pkg
// Shared definitions for the input conditioning front end:
//   - cond_state_e : 2-bit per-channel debounce FSM state encoding
//   - CLK_HZ, DEBOUNCE_MS, HOLD_MS : default timing figures
//   - DEF_DEBOUNCE_CYCLES, DEF_HOLD_CYCLES : the same figures in clock cycles
// -----------------------------------------------------------------------------
package neurosync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } cond_state_e;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 20;
    localparam int HOLD_MS     = 1000;

    // Converts a duration in milliseconds to clock cycles at CLK_HZ.
    function automatic int cycles_from_ms(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int DEF_DEBOUNCE_CYCLES = cycles_from_ms(DEBOUNCE_MS);
    localparam int DEF_HOLD_CYCLES     = cycles_from_ms(HOLD_MS);

endpackage

// File: rtl/conditioner_channel.sv
// -----------------------------------------------------------------------------
// conditioner_channel
// One push-button channel: optional polarity inversion, 2-FF synchronizer,
// counter-based debounce FSM and press / release / long-press pulse outputs.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronized cycles needed to accept a change (>= 2)
//   HOLD_CYCLES     : cycles in PRESSED before hold_pulse fires (0 = disabled)
//   INVERT          : 1 when raw is active-low
//
// Ports:
//   clock         in  : system clock, rising edge
//   reset         in  : asynchronous active-low reset
//   raw           in  : unsynchronized button level
//   level         out : debounced active-high level (registered)
//   press_pulse   out : one-cycle pulse on accepted press (registered)
//   release_pulse out : one-cycle pulse on accepted release (registered)
//   hold_pulse    out : one-cycle pulse when a press has lasted HOLD_CYCLES
//   press_next    out : combinational value press_pulse takes on the next edge,
//                       lets the bank register its aggregate in the same cycle
// -----------------------------------------------------------------------------
module conditioner_channel
    import neurosync_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter bit INVERT          = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse,
    output logic press_next
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HCNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam bit HOLD_EN = (HOLD_CYCLES > 0);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST =
        HCNT_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

    logic              sync1;
    logic              sync2;
    cond_state_e       state,  state_n;
    logic [CNT_W-1:0]  cnt,    cnt_n;
    logic [HCNT_W-1:0] hcnt,   hcnt_n;
    logic [HCNT_W-1:0] hcnt_inc;
    logic              level_n;
    logic              release_n;
    logic              hold_n;

    // Stage: polarity fix and two-flop synchronizer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw ^ INVERT;
            sync2 <= sync1;
        end
    end

    assign hcnt_inc = hcnt + 1'b1;

    // Stage: debounce FSM next-state and pulse decode
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hcnt_n     = hcnt;
        press_next = 1'b0;
        release_n  = 1'b0;
        hold_n     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sync2) begin
                    state_n = ST_DEB_PRESS;
                    cnt_n   = CNT_W'(1);
                end else begin
                    cnt_n   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!sync2) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n    = ST_PRESSED;
                    press_next = 1'b1;
                    cnt_n      = '0;
                    hcnt_n     = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!sync2) begin
                    state_n = ST_DEB_RELEASE;
                    cnt_n   = CNT_W'(1);
                end else if (HOLD_EN && (hcnt != HOLD_LAST)) begin
                    // Saturating count: the pulse fires only on the step that
                    // lands on HOLD_LAST, so a long hold never repeats it.
                    hcnt_n = hcnt_inc;
                    hold_n = (hcnt_inc == HOLD_LAST);
                end
            end
            ST_DEB_RELEASE: begin
                // A bounce back to 1 resumes PRESSED with hcnt untouched, so
                // neither press nor the hold timer restarts.
                if (sync2) begin
                    state_n = ST_PRESSED;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n   = ST_IDLE;
                    release_n = 1'b1;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign level_n = (state_n == ST_PRESSED) || (state_n == ST_DEB_RELEASE);

    // Stage: state, counters and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            hcnt          <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            hcnt          <= hcnt_n;
            level         <= level_n;
            press_pulse   <= press_next;
            release_pulse <= release_n;
            hold_pulse    <= hold_n;
        end
    end

endmodule

// File: rtl/input_conditioner_bank.sv
// -----------------------------------------------------------------------------
// input_conditioner_bank
// Bank of N_INPUTS independent push-button conditioners feeding the game
// controller, plus an aggregate press pulse for the idle timer.
//
// Parameters:
//   N_INPUTS        : number of channels
//   DEBOUNCE_CYCLES : stable cycles needed to accept a level change (>= 2)
//   HOLD_CYCLES     : cycles in PRESSED before hold_pulse (0 = disabled)
//   INVERT_MASK     : bit i = 1 marks raw[i] as active-low
//
// Ports:
//   clock         in  : system clock, rising edge
//   reset         in  : asynchronous active-low reset
//   raw           in  : [N_INPUTS] unsynchronized button levels
//   level         out : [N_INPUTS] debounced active-high levels
//   press_pulse   out : [N_INPUTS] one-cycle press pulses
//   release_pulse out : [N_INPUTS] one-cycle release pulses
//   hold_pulse    out : [N_INPUTS] one-cycle long-press pulses
//   any_press     out : OR of press_pulse, aligned with it
// -----------------------------------------------------------------------------
module input_conditioner_bank
    import neurosync_pkg::*;
#(
    parameter int                  N_INPUTS        = 9,
    parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                  HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter logic [N_INPUTS-1:0] INVERT_MASK     = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] raw,
    output logic [N_INPUTS-1:0] level,
    output logic [N_INPUTS-1:0] press_pulse,
    output logic [N_INPUTS-1:0] release_pulse,
    output logic [N_INPUTS-1:0] hold_pulse,
    output logic                any_press
);

    logic [N_INPUTS-1:0] press_next;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_chan
        conditioner_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .INVERT          (INVERT_MASK[i])
        ) u_chan (
            .clock         (clock),
            .reset         (reset),
            .raw           (raw[i]),
            .level         (level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .hold_pulse    (hold_pulse[i]),
            .press_next    (press_next[i])
        );
    end

    // Stage: aggregate press, registered from the channels' next-press terms
    // so it lands in the same cycle as the individual pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_next;
        end
    end

endmodule

// File: tb/tb_input_conditioner_bank.sv
module tb_input_conditioner_bank;

    localparam int N  = 9;
    localparam int DB = 4;
    localparam int HC = 10;

    logic         clock;
    logic         reset;
    logic [N-1:0] raw;
    logic [N-1:0] level;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] hold_pulse;
    logic         any_press;

    int tests;
    int fails;

    input_conditioner_bank #(
        .N_INPUTS        (N),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC),
        .INVERT_MASK     (9'h001)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .raw           (raw),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .hold_pulse    (hold_pulse),
        .any_press     (any_press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int e = 1; e <= 3; e++) begin
            tick();
            tests++;
            if ({level, press_pulse, release_pulse, hold_pulse, any_press} !== '0) begin
                fails++;
                $display("FAIL reset_hold cyc %0d: lvl=%h prs=%h rel=%h hld=%h any=%b, required all 0",
                         e, level, press_pulse, release_pulse, hold_pulse, any_press);
            end
        end
        reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            tests++;
            if ({level, press_pulse, release_pulse, hold_pulse, any_press} !== '0) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: lvl=%h prs=%h rel=%h hld=%h any=%b, required all 0",
                         e, level, press_pulse, release_pulse, hold_pulse, any_press);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [N-1:0] exp_p, exp_h, exp_l;
        raw[1] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_p = (e == 6)  ? 9'h002 : 9'h000;
            exp_h = (e == 15) ? 9'h002 : 9'h000;
            exp_l = (e >= 6)  ? 9'h002 : 9'h000;
            tests++;
            if (press_pulse !== exp_p) begin
                fails++;
                $display("FAIL clean_press edge %0d: press_pulse=%h required %h", e, press_pulse, exp_p);
            end
            tests++;
            if (any_press !== (e == 6)) begin
                fails++;
                $display("FAIL clean_any edge %0d: any_press=%b required %b", e, any_press, (e == 6));
            end
            tests++;
            if (hold_pulse !== exp_h) begin
                fails++;
                $display("FAIL clean_hold edge %0d: hold_pulse=%h required %h", e, hold_pulse, exp_h);
            end
            tests++;
            if (level !== exp_l || release_pulse !== 9'h000) begin
                fails++;
                $display("FAIL clean_level edge %0d: level=%h rel=%h required %h / 000",
                         e, level, release_pulse, exp_l);
            end
        end
    endtask

    task automatic test_glitch();
        logic [2:0] pat;
        pat = 3'b011;  // applied LSB first: 1,1,0
        raw[2] = 1'b1;
        for (int e = 1; e <= 3; e++) tick();
        raw[2] = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            tests++;
            if (press_pulse !== 9'h000 || level[2] !== 1'b0) begin
                fails++;
                $display("FAIL glitch_single cyc %0d: press_pulse=%h level2=%b required 000 / 0",
                         e, press_pulse, level[2]);
            end
        end
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 3; k++) begin
                raw[2] = pat[k];
                tick();
                tests++;
                if (press_pulse !== 9'h000 || any_press !== 1'b0 || level[2] !== 1'b0) begin
                    fails++;
                    $display("FAIL glitch_train r%0d k%0d: press_pulse=%h any=%b level2=%b required 000/0/0",
                             r, k, press_pulse, any_press, level[2]);
                end
            end
        end
        raw[2] = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
    endtask

    task automatic test_release_bounce();
        logic [N-1:0] exp_r;
        raw[1] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_r = (e == 8) ? 9'h002 : 9'h000;
            tests++;
            if (release_pulse !== exp_r) begin
                fails++;
                $display("FAIL bounce_release edge %0d: release_pulse=%h required %h", e, release_pulse, exp_r);
            end
            tests++;
            if (press_pulse !== 9'h000 || hold_pulse !== 9'h000) begin
                fails++;
                $display("FAIL bounce_repress edge %0d: press=%h hold=%h required 000/000",
                         e, press_pulse, hold_pulse);
            end
            tests++;
            if (level[1] !== (e < 8)) begin
                fails++;
                $display("FAIL bounce_level edge %0d: level1=%b required %b", e, level[1], (e < 8));
            end
            if (e == 1) raw[1] = 1'b1;
            if (e == 2) raw[1] = 1'b0;
        end
    endtask

    task automatic test_active_low();
        logic [N-1:0] exp_p, exp_h, exp_r;
        for (int e = 1; e <= 3; e++) begin
            tick();
            tests++;
            if (level[0] !== 1'b0 || press_pulse[0] !== 1'b0) begin
                fails++;
                $display("FAIL actlow_idle cyc %0d: level0=%b press0=%b required 0/0",
                         e, level[0], press_pulse[0]);
            end
        end
        raw[0] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_p = (e == 6)  ? 9'h001 : 9'h000;
            exp_h = (e == 15) ? 9'h001 : 9'h000;
            tests++;
            if (press_pulse !== exp_p || hold_pulse !== exp_h) begin
                fails++;
                $display("FAIL actlow_press edge %0d: press=%h hold=%h required %h/%h",
                         e, press_pulse, hold_pulse, exp_p, exp_h);
            end
            tests++;
            if (level[0] !== (e >= 6)) begin
                fails++;
                $display("FAIL actlow_level edge %0d: level0=%b required %b", e, level[0], (e >= 6));
            end
        end
        raw[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_r = (e == 6) ? 9'h001 : 9'h000;
            tests++;
            if (release_pulse !== exp_r || level[0] !== (e < 6)) begin
                fails++;
                $display("FAIL actlow_release edge %0d: rel=%h level0=%b required %h/%b",
                         e, release_pulse, level[0], exp_r, (e < 6));
            end
        end
    endtask

    task automatic test_simul_reset();
        logic [N-1:0] exp_p, exp_l, exp_r;
        raw[3] = 1'b1;
        raw[5] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_p = (e == 6) ? 9'h028 : 9'h000;
            tests++;
            if (press_pulse !== exp_p || any_press !== (e == 6)) begin
                fails++;
                $display("FAIL simul_press edge %0d: press=%h any=%b required %h/%b",
                         e, press_pulse, any_press, exp_p, (e == 6));
            end
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({level, press_pulse, release_pulse, hold_pulse, any_press} !== '0) begin
            fails++;
            $display("FAIL reset_async: lvl=%h prs=%h rel=%h hld=%h any=%b required all 0",
                     level, press_pulse, release_pulse, hold_pulse, any_press);
        end
        for (int e = 1; e <= 3; e++) begin
            tick();
            tests++;
            if ({level, press_pulse, release_pulse, hold_pulse, any_press} !== '0) begin
                fails++;
                $display("FAIL reset_midhold cyc %0d: lvl=%h prs=%h rel=%h hld=%h any=%b required all 0",
                         e, level, press_pulse, release_pulse, hold_pulse, any_press);
            end
        end
        reset = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_p = (e == 6) ? 9'h028 : 9'h000;
            exp_l = (e >= 6) ? 9'h028 : 9'h000;
            tests++;
            if (press_pulse !== exp_p || level !== exp_l) begin
                fails++;
                $display("FAIL repress edge %0d: press=%h level=%h required %h/%h",
                         e, press_pulse, level, exp_p, exp_l);
            end
            tests++;
            if (release_pulse !== 9'h000 || hold_pulse !== 9'h000) begin
                fails++;
                $display("FAIL repress_quiet edge %0d: rel=%h hold=%h required 000/000",
                         e, release_pulse, hold_pulse);
            end
        end
        raw[3] = 1'b0;
        raw[5] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_r = (e == 6) ? 9'h028 : 9'h000;
            tests++;
            if (release_pulse !== exp_r) begin
                fails++;
                $display("FAIL simul_release edge %0d: rel=%h required %h", e, release_pulse, exp_r);
            end
        end
    endtask

    task automatic test_saturation();
        int n_press;
        int n_hold;
        n_press = 0;
        n_hold  = 0;
        raw[4] = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            tick();
            if (press_pulse[4]) n_press++;
            if (hold_pulse[4])  n_hold++;
            tests++;
            if (level[4] !== (e >= 6)) begin
                fails++;
                $display("FAIL sat_level edge %0d: level4=%b required %b", e, level[4], (e >= 6));
            end
            tests++;
            if ((press_pulse & hold_pulse) !== 9'h000 || (press_pulse & release_pulse) !== 9'h000 ||
                (hold_pulse & release_pulse) !== 9'h000) begin
                fails++;
                $display("FAIL sat_exclusive edge %0d: press=%h hold=%h rel=%h required disjoint",
                         e, press_pulse, hold_pulse, release_pulse);
            end
            if (e == 15) begin
                tests++;
                if (hold_pulse !== 9'h010) begin
                    fails++;
                    $display("FAIL sat_hold_time edge 15: hold=%h required 010", hold_pulse);
                end
            end
        end
        tests++;
        if (n_press !== 1) begin
            fails++;
            $display("FAIL sat_press_count: got %0d required 1", n_press);
        end
        tests++;
        if (n_hold !== 1) begin
            fails++;
            $display("FAIL sat_hold_count: got %0d required 1", n_hold);
        end
        raw[4] = 1'b0;
        for (int e = 1; e <= 8; e++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        raw   = 9'h001;  // channel 0 is active-low, so its idle level is 1
        test_reset();
        test_clean_press();
        test_glitch();
        test_release_bounce();
        test_active_low();
        test_simul_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
